// File: rtl/hid_kbd_pkg.sv
// Shared definitions for the HID boot-keyboard to ps2_key event path:
// report geometry, error usages, ps2_key field positions and FSM states.
package hid_kbd_pkg;

    localparam int unsigned NUM_KEYS = 6;
    localparam logic [7:0]  MOD_BASE = 8'hE0;

    localparam logic [7:0] ERR_ROLLOVER  = 8'h01;
    localparam logic [7:0] ERR_POSTFAIL  = 8'h02;
    localparam logic [7:0] ERR_UNDEFINED = 8'h03;

    localparam int unsigned PS2_TOGGLE  = 10;
    localparam int unsigned PS2_PRESSED = 9;
    localparam int unsigned PS2_EXT     = 8;

    // Scan index ranges: modifiers [0,8), breaks [8,14), makes [14,20).
    localparam logic [4:0] IDX_BRK  = 5'd8;
    localparam logic [4:0] IDX_MAKE = 5'd14;
    localparam logic [4:0] IDX_END  = 5'd20;

    typedef logic [NUM_KEYS-1:0][7:0] keyset_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_LOOKUP,
        ST_EMIT,
        ST_GAP
    } state_t;

    function automatic logic has_error(input keyset_t k);
        logic e;
        e = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (k[i] == ERR_ROLLOVER || k[i] == ERR_POSTFAIL || k[i] == ERR_UNDEFINED)
                e = 1'b1;
        end
        return e;
    endfunction

endpackage

// File: rtl/hid2ps2_key.sv
// USB HID usage ID to PS/2 set-2 scancode translator, one registered cycle.
// Result is {extended, scancode}; 0 means the usage has no mapping.
module hid2ps2_key (
    input  logic       clk,
    input  logic [7:0] usb,
    output logic [8:0] ps2
);

    logic [8:0] lut;

    always_comb begin
        lut = '0;
        case (usb)
            8'h04: lut = 9'h01C;  8'h05: lut = 9'h032;  8'h06: lut = 9'h021;
            8'h07: lut = 9'h023;  8'h08: lut = 9'h024;  8'h09: lut = 9'h02B;
            8'h0A: lut = 9'h034;  8'h0B: lut = 9'h033;  8'h0C: lut = 9'h043;
            8'h0D: lut = 9'h03B;  8'h0E: lut = 9'h042;  8'h0F: lut = 9'h04B;
            8'h10: lut = 9'h03A;  8'h11: lut = 9'h031;  8'h12: lut = 9'h044;
            8'h13: lut = 9'h04D;  8'h14: lut = 9'h015;  8'h15: lut = 9'h02D;
            8'h16: lut = 9'h01B;  8'h17: lut = 9'h02C;  8'h18: lut = 9'h03C;
            8'h19: lut = 9'h02A;  8'h1A: lut = 9'h01D;  8'h1B: lut = 9'h022;
            8'h1C: lut = 9'h035;  8'h1D: lut = 9'h01A;
            8'h1E: lut = 9'h016;  8'h1F: lut = 9'h01E;  8'h20: lut = 9'h026;
            8'h21: lut = 9'h025;  8'h22: lut = 9'h02E;  8'h23: lut = 9'h036;
            8'h24: lut = 9'h03D;  8'h25: lut = 9'h03E;  8'h26: lut = 9'h046;
            8'h27: lut = 9'h045;
            8'h28: lut = 9'h05A;  8'h29: lut = 9'h076;  8'h2A: lut = 9'h066;
            8'h2B: lut = 9'h00D;  8'h2C: lut = 9'h029;
            8'h4F: lut = 9'h174;  8'h50: lut = 9'h16B;  8'h51: lut = 9'h172;
            8'h52: lut = 9'h175;
            8'hE0: lut = 9'h014;  8'hE1: lut = 9'h012;  8'hE2: lut = 9'h011;
            8'hE3: lut = 9'h11F;  8'hE4: lut = 9'h114;  8'hE5: lut = 9'h059;
            8'hE6: lut = 9'h111;  8'hE7: lut = 9'h127;
            default: lut = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        ps2 <= lut;
    end

endmodule

// File: rtl/hid_key_event.sv
// Diffs successive HID boot-keyboard reports into make/break events and
// strobes each one out as a MiSTer ps2_key word through a shared translator.
module hid_key_event
    import hid_kbd_pkg::*;
#(
    parameter int unsigned EVENT_GAP = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        report_valid,
    input  logic [7:0]  modifiers,
    input  logic [47:0] keys,
    output logic [10:0] ps2_key,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned GAP_W = (EVENT_GAP > 1) ? $clog2(EVENT_GAP) : 1;

    state_t           state;
    logic [4:0]       idx;
    logic             lk_phase;
    logic [7:0]       work_mod, prev_mod, pend_mod;
    keyset_t          work_keys, prev_keys, pend_keys;
    logic             pend_valid;
    logic [7:0]       usb;
    logic [8:0]       xlat, xlat_q;
    logic             ev_pressed;
    logic [GAP_W-1:0] gap_cnt;

    keyset_t    new_keys;
    logic       rv_ok;
    logic [2:0] mod_sel, brk_sel, mk_sel;
    logic [7:0] brk_code, mk_code;
    logic       in_new, in_prev, dup;
    logic       ev_hit, ev_make;
    logic [7:0] ev_code;

    assign new_keys = keyset_t'(keys);
    assign rv_ok    = report_valid && !has_error(new_keys);

    hid2ps2_key u_xlat (
        .clk (clk),
        .usb (usb),
        .ps2 (xlat)
    );

    always_comb begin
        mod_sel  = idx[2:0];
        brk_sel  = 3'(idx - IDX_BRK);
        mk_sel   = 3'(idx - IDX_MAKE);
        brk_code = prev_keys[brk_sel];
        mk_code  = work_keys[mk_sel];
        in_new   = 1'b0;
        in_prev  = 1'b0;
        dup      = 1'b0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if (work_keys[k] == brk_code) in_new = 1'b1;
            if (prev_keys[k] == mk_code) in_prev = 1'b1;
            if (3'(k) < mk_sel && work_keys[k] == mk_code) dup = 1'b1;
        end
        ev_hit  = 1'b0;
        ev_make = 1'b0;
        ev_code = MOD_BASE | {5'b0, mod_sel};
        if (idx < IDX_BRK) begin
            ev_hit  = work_mod[mod_sel] ^ prev_mod[mod_sel];
            ev_make = work_mod[mod_sel];
        end else if (idx < IDX_MAKE) begin
            ev_hit  = (brk_code != 8'h00) && !in_new;
            ev_code = brk_code;
        end else if (idx < IDX_END) begin
            // Only the first slot holding a given new key may report its make.
            ev_hit  = (mk_code != 8'h00) && !in_prev && !dup;
            ev_code = mk_code;
            ev_make = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            lk_phase   <= 1'b0;
            work_mod   <= '0;
            prev_mod   <= '0;
            pend_mod   <= '0;
            work_keys  <= '0;
            prev_keys  <= '0;
            pend_keys  <= '0;
            pend_valid <= 1'b0;
            usb        <= '0;
            xlat_q     <= '0;
            ev_pressed <= 1'b0;
            gap_cnt    <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            ps2_key    <= '0;
        end else begin
            overrun <= 1'b0;
            if (rv_ok && state != ST_IDLE) begin
                pend_mod   <= modifiers;
                pend_keys  <= new_keys;
                pend_valid <= 1'b1;
                overrun    <= pend_valid;
            end
            case (state)
                ST_IDLE: begin
                    if (pend_valid) begin
                        work_mod   <= pend_mod;
                        work_keys  <= pend_keys;
                        pend_valid <= rv_ok;
                        if (rv_ok) begin
                            pend_mod  <= modifiers;
                            pend_keys <= new_keys;
                        end
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SCAN;
                    end else if (rv_ok) begin
                        work_mod  <= modifiers;
                        work_keys <= new_keys;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (idx == IDX_END) begin
                        prev_mod  <= work_mod;
                        prev_keys <= work_keys;
                        busy      <= pend_valid || rv_ok;
                        state     <= ST_IDLE;
                    end else if (ev_hit) begin
                        usb        <= ev_code;
                        ev_pressed <= ev_make;
                        lk_phase   <= 1'b0;
                        state      <= ST_LOOKUP;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                ST_LOOKUP: begin
                    if (!lk_phase) begin
                        lk_phase <= 1'b1;
                    end else begin
                        xlat_q <= xlat;
                        state  <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (xlat_q == '0) begin
                        idx   <= idx + 5'd1;
                        state <= ST_SCAN;
                    end else begin
                        ps2_key[PS2_TOGGLE]  <= ~ps2_key[PS2_TOGGLE];
                        ps2_key[PS2_PRESSED] <= ev_pressed;
                        ps2_key[PS2_EXT]     <= xlat_q[8];
                        ps2_key[7:0]         <= xlat_q[7:0];
                        gap_cnt              <= '0;
                        state                <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(EVENT_GAP - 1)) begin
                        idx   <= idx + 5'd1;
                        state <= ST_SCAN;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hid_key_event.sv
// Bench for hid_key_event: directed steps plus random reports, with the
// expected event list derived from a report-diff model kept here.
module tb_hid_key_event;

    localparam int unsigned GAP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        report_valid;
    logic [7:0]  modifiers;
    logic [47:0] keys;
    logic [10:0] ps2_key;
    logic        busy;
    logic        overrun;

    hid_key_event #(.EVENT_GAP(GAP)) dut (
        .clk          (clk),
        .reset        (reset),
        .report_valid (report_valid),
        .modifiers    (modifiers),
        .keys         (keys),
        .ps2_key      (ps2_key),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  ev;
        int unsigned t;
    } obs_t;

    int unsigned cyc = 0;
    obs_t        obs_q[$];
    logic        last_tog = 1'b0;
    int unsigned ovr_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            last_tog <= 1'b0;
        end else begin
            if (ps2_key[10] !== last_tog) begin
                obs_q.push_back('{ps2_key[9:0], cyc});
                last_tog <= ps2_key[10];
            end
            if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
        end
    end

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned obs_rd = 0;
    int unsigned ev_base = 0;
    int unsigned strobe_cyc = 0;
    logic [9:0]  exp_q[$];
    logic [7:0]  m_prev_mod = '0;
    logic [7:0]  m_prev_keys[6] = '{default: 8'h00};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] tr(input logic [7:0] u);
        case (u)
            8'h04: return 9'h01C;
            8'h05: return 9'h032;
            8'h16: return 9'h01B;
            8'h1E: return 9'h016;
            8'h4F: return 9'h174;
            8'h50: return 9'h16B;
            8'hE0: return 9'h014;
            8'hE1: return 9'h012;
            8'hE2: return 9'h011;
            8'hE3: return 9'h11F;
            8'hE4: return 9'h114;
            8'hE5: return 9'h059;
            8'hE6: return 9'h111;
            8'hE7: return 9'h127;
            default: return 9'h000;
        endcase
    endfunction

    function automatic bit member(input logic [7:0] a[6], input logic [7:0] v, input int lim);
        for (int i = 0; i < lim; i++) if (a[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_ev(input logic [7:0] code, input logic pressed);
        logic [8:0] t;
        t = tr(code);
        if (t != 9'h000) exp_q.push_back({pressed, t});
    endtask

    // Expected events for a report: modifier flips, released keys, new keys.
    task automatic model(input logic [7:0] m, input logic [47:0] k);
        logic [7:0] nk[6];
        bit err;
        err = 1'b0;
        for (int i = 0; i < 6; i++) begin
            nk[i] = k[8*i +: 8];
            if (nk[i] >= 8'h01 && nk[i] <= 8'h03) err = 1'b1;
        end
        if (err) return;
        for (int b = 0; b < 8; b++)
            if (m[b] != m_prev_mod[b]) push_ev(8'hE0 + 8'(b), m[b]);
        for (int j = 0; j < 6; j++)
            if (m_prev_keys[j] != 8'h00 && !member(nk, m_prev_keys[j], 6))
                push_ev(m_prev_keys[j], 1'b0);
        for (int j = 0; j < 6; j++)
            if (nk[j] != 8'h00 && !member(m_prev_keys, nk[j], 6) && !member(nk, nk[j], j))
                push_ev(nk[j], 1'b1);
        m_prev_mod = m;
        m_prev_keys = nk;
    endtask

    task automatic send(input logic [7:0] m, input logic [47:0] k);
        @(negedge clk);
        modifiers = m;
        keys = k;
        report_valid = 1'b1;
        strobe_cyc = cyc + 1;
        @(negedge clk);
        report_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int unsigned guard;
        guard = 0;
        repeat (3) @(negedge clk);
        while (busy === 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_idle"}, 32'(guard < 5000), 32'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic check_events(input string tag);
        int unsigned n;
        n = obs_q.size() - obs_rd;
        check({tag, "_count"}, n, exp_q.size());
        for (int i = 0; i < int'(n) && i < exp_q.size(); i++)
            check({tag, "_ev"}, 32'(obs_q[obs_rd + i].ev), 32'(exp_q[i]));
        ev_base = obs_rd;
        obs_rd = obs_rd + n;
        exp_q.delete();
    endtask

    task automatic step(input string tag, input logic [7:0] m, input logic [47:0] k);
        model(m, k);
        send(m, k);
        wait_idle(tag);
        check_events(tag);
    endtask

    initial begin
        logic [10:0] held;
        int unsigned ovr0;
        logic [47:0] rk;
        logic [7:0]  rm;
        logic [7:0]  pool[10];
        pool = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h05, 8'h16, 8'h4F, 8'h50, 8'h48, 8'h1E};

        reset = 1'b1;
        report_valid = 1'b0;
        modifiers = '0;
        keys = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ps2_key", 32'(ps2_key), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);

        step("make_a", 8'h00, 48'h04);
        check("make_a_word", 32'(ps2_key), 32'h61C);
        check("make_a_busy", 32'(busy), 32'h0);
        step("break_a", 8'h00, 48'h00);
        check("break_a_word", 32'(ps2_key), 32'h01C);
        step("repeat_zero", 8'h00, 48'h00);

        step("mod_ctl_shift", 8'h03, 48'h00);
        if (obs_q.size() >= ev_base + 2) begin
            check("latency", obs_q[ev_base].t - strobe_cyc, 32'd4);
            check("spacing", obs_q[ev_base + 1].t - obs_q[ev_base].t, GAP + 4);
        end
        step("mod_release", 8'h00, 48'h00);

        step("shift_right", 8'h02, 48'h4F);
        step("shift_right_rel", 8'h00, 48'h00);

        step("hold_a", 8'h00, 48'h04);
        step("rollover", 8'h00, 48'h010101010101);
        step("after_roll", 8'h00, 48'h00);

        step("dup_make", 8'h00, 48'h0505);
        step("dup_release", 8'h00, 48'h00);
        held = ps2_key;
        step("pause", 8'h00, 48'h48);
        check("pause_hold", 32'(ps2_key), 32'(held));
        step("pause_rel", 8'h00, 48'h00);

        // Three strobes during one report: the middle one must be dropped.
        ovr0 = ovr_cnt;
        model(8'h00, 48'h50_16_05_04);
        send(8'h00, 48'h50_16_05_04);
        repeat (2) @(negedge clk);
        send(8'h00, 48'h4F);
        send(8'h00, 48'h04);
        model(8'h00, 48'h04);
        wait_idle("overrun");
        check_events("overrun");
        check("overrun_pulses", ovr_cnt - ovr0, 32'd1);

        send(8'hFF, 48'h00);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_ps2_key", 32'(ps2_key), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        obs_rd = obs_q.size();
        exp_q.delete();
        m_prev_mod = '0;
        m_prev_keys = '{default: 8'h00};
        step("post_rst", 8'h00, 48'h04);
        check("post_rst_word", 32'(ps2_key), 32'h61C);

        for (int it = 0; it < 40; it++) begin
            rm = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
            for (int s = 0; s < 6; s++) rk[8*s +: 8] = pool[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) rk[8*$urandom_range(0, 5) +: 8] = 8'($urandom_range(1, 3));
            step("random", rm, rk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
